// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with register pointer, auto-increment reads/writes and strobe-based register port
module i2c_target_regs #(
    parameter logic [6:0] ADDRESS = 7'h69,
    parameter int NUM_REGS = 16,
    parameter bit AUTO_INC = 1'b1,
    parameter int SYNC_STAGES = 2,
    localparam int AW = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    wr_data,
    output logic          wr_en,
    input  logic [7:0]    rd_data,
    output logic          rd_en,
    output logic          start,
    output logic          stop,
    output logic          busy
);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT
    } state_t;
    localparam logic [8:0] NR = 9'(NUM_REGS);
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det, bus_evt;
    logic rx_state, ack_state, bit_done, addr_ok, rd_acked;
    logic [2:0] cnt;
    logic [7:0] sr, rx_byte;
    logic phase, rw;
    logic sda_n, wr_en_n, rd_en_n, busy_n;
    logic [AW-1:0] next_addr;
    assign scl_s = scl_q[SYNC_STAGES-1];
    assign sda_s = sda_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det = scl_s & scl_d & ~sda_d & sda_s;
    assign bus_evt = start_det | stop_det;
    assign rx_state = state inside {DEV_ADDR, REG_ADDR, WR_DATA};
    assign ack_state = state inside {ACK_DEV, ACK_REG, ACK_WR};
    assign bit_done = rx_state && scl_rise && cnt == 3'd7;
    assign rx_byte = {sr[6:0], sda_s};
    assign addr_ok = {1'b0, rx_byte} < NR;
    assign rd_acked = state == RD_ACK && scl_rise && !sda_s;
    assign next_addr = (reg_addr == AW'(NUM_REGS - 1)) ? '0 : reg_addr + AW'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sda_o <= 1'b1;
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            sda_o <= sda_n;
            wr_en <= wr_en_n;
            rd_en <= rd_en_n;
            busy <= busy_n;
        end
    end
    always_comb begin
        state_n = state;
        if (stop_det) state_n = IDLE;
        else if (start_det) state_n = DEV_ADDR;
        else case (state)
            DEV_ADDR: if (bit_done) state_n = (rx_byte[7:1] == ADDRESS) ? ACK_DEV : WAIT;
            ACK_DEV: if (scl_fall && phase) state_n = rw ? RD_DATA : REG_ADDR;
            REG_ADDR: if (bit_done) state_n = addr_ok ? ACK_REG : WAIT;
            ACK_REG, ACK_WR: if (scl_fall && phase) state_n = WR_DATA;
            WR_DATA: if (bit_done) state_n = ACK_WR;
            RD_DATA: if (scl_fall && cnt == 3'd7) state_n = RD_ACK;
            RD_ACK: begin
                if (scl_rise && sda_s) state_n = WAIT;
                else if (scl_fall && phase) state_n = RD_DATA;
            end
            default: ;
        endcase
    end
    // ACK slots pull low on the first falling edge (phase 0) and release on the second
    always_comb begin
        sda_n = bus_evt ? 1'b1 :
                ack_state ? (scl_fall ? phase : sda_o) :
                (state == RD_DATA) ? (rd_en ? rd_data[7] : scl_fall ? (cnt == 3'd7 || sr[6]) : sda_o) :
                1'b1;
        wr_en_n = !bus_evt && state == ACK_WR && scl_fall && !phase;
        rd_en_n = !bus_evt && scl_fall && phase && ((state == ACK_DEV && rw) || state == RD_ACK);
        busy_n = (state_n == IDLE || state_n == WAIT) ? 1'b0 :
                 (state == DEV_ADDR && state_n == ACK_DEV) ? 1'b1 : busy;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
            cnt <= '0;
            sr <= '0;
            phase <= 1'b0;
            rw <= 1'b0;
            reg_addr <= '0;
            wr_data <= '0;
            start <= 1'b0;
            stop <= 1'b0;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
            scl_d <= scl_s;
            sda_d <= sda_s;
            start <= start_det & ~stop_det;
            stop <= stop_det;
            if (bus_evt || state_n != state) cnt <= '0;
            else if ((rx_state && scl_rise) || (state == RD_DATA && scl_fall)) cnt <= cnt + 3'd1;
            if (bus_evt || state_n != state) phase <= 1'b0;
            else if ((ack_state && scl_fall) || rd_acked) phase <= 1'b1;
            if (rx_state && scl_rise) sr <= rx_byte;
            else if (state == RD_DATA && rd_en) sr <= rd_data;
            else if (state == RD_DATA && scl_fall) sr <= {sr[6:0], 1'b0};
            if (state == DEV_ADDR && bit_done) rw <= sda_s;
            if (wr_en_n) wr_data <= sr;
            if (state == REG_ADDR && state_n == ACK_REG) reg_addr <= rx_byte[AW-1:0];
            else if (AUTO_INC && (wr_en || rd_acked)) reg_addr <= next_addr;
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C controller with an event scoreboard for wr_en/rd_en/start/stop
module tb_i2c_target_regs;
    localparam int Q = 5;
    typedef struct {
        logic [7:0] k;
        logic [7:0] a;
        logic [7:0] d;
    } evt_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic scl_i, sda_i, sda_o, wr_en, rd_en, start, stop, busy;
    logic [3:0] reg_addr;
    logic [7:0] wr_data, rd_data;
    int total = 0;
    int passed = 0;
    evt_t exp_q[$];
    evt_t got_e, want_e;

    always #5 clk = ~clk;
    assign scl_i = scl_m;
    assign sda_i = sda_m & sda_o;
    assign rd_data = 8'h40 + 8'(reg_addr);

    i2c_target_regs dut (
        .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_o(sda_o),
        .reg_addr(reg_addr), .wr_data(wr_data), .wr_en(wr_en), .rd_data(rd_data),
        .rd_en(rd_en), .start(start), .stop(stop), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic expect_evt(input logic [7:0] k, input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{k, a, d});
    endtask

    always @(negedge clk) begin
        if (!reset && (wr_en || rd_en || start || stop)) begin
            got_e.k = wr_en ? "W" : rd_en ? "R" : start ? "S" : "P";
            got_e.a = (wr_en || rd_en) ? 8'(reg_addr) : 8'h00;
            got_e.d = wr_en ? wr_data : 8'h00;
            want_e = (exp_q.size() == 0) ? '{"-", 8'h00, 8'h00} : exp_q.pop_front();
            check($sformatf("event %s", want_e.k), {8'h00, got_e.k, got_e.a, got_e.d},
                  {8'h00, want_e.k, want_e.a, want_e.d});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_start();
        expect_evt("S", 8'h00, 8'h00);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_stop();
        expect_evt("P", 8'h00, 8'h00);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(Q);
            scl_m = 1'b1; tick(2 * Q);
            scl_m = 1'b0; tick(Q);
        end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        check(name, 32'(sda_i), 32'(exp_ack));
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic recv_byte(input logic ack, input logic [7:0] exp_b, input string name);
        logic [7:0] got;
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(Q);
            got[i] = sda_i;
            tick(Q);
            scl_m = 1'b0; tick(Q);
        end
        check(name, 32'(got), 32'(exp_b));
        sda_m = ack; tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
        sda_m = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("reset sda_o", 32'(sda_o), 1);
        check("reset reg_addr", 32'(reg_addr), 0);
        check("reset busy", 32'(busy), 0);
        check("reset wr_en", 32'(wr_en), 0);
        check("reset rd_en", 32'(rd_en), 0);
        reset = 1'b0;
        tick(5);
        // single write to register 3
        send_start();
        send_byte(8'hD2, 1'b0, "t1 dev ack");
        check("t1 busy", 32'(busy), 1);
        send_byte(8'h03, 1'b0, "t1 ptr ack");
        expect_evt("W", 8'd3, 8'hA5);
        send_byte(8'hA5, 1'b0, "t1 data ack");
        send_stop();
        tick(Q);
        check("t1 reg_addr", 32'(reg_addr), 4);
        check("t1 busy after stop", 32'(busy), 0);
        // burst write wrapping 14 -> 15 -> 0
        send_start();
        send_byte(8'hD2, 1'b0, "t2 dev ack");
        send_byte(8'h0E, 1'b0, "t2 ptr ack");
        expect_evt("W", 8'd14, 8'h11);
        send_byte(8'h11, 1'b0, "t2 d0 ack");
        expect_evt("W", 8'd15, 8'h22);
        send_byte(8'h22, 1'b0, "t2 d1 ack");
        expect_evt("W", 8'd0, 8'h33);
        send_byte(8'h33, 1'b0, "t2 d2 ack");
        send_stop();
        tick(Q);
        check("t2 reg_addr", 32'(reg_addr), 1);
        // combined pointer write + repeated START + read
        send_start();
        send_byte(8'hD2, 1'b0, "t3 dev ack");
        send_byte(8'h05, 1'b0, "t3 ptr ack");
        send_start();
        expect_evt("R", 8'd5, 8'h00);
        send_byte(8'hD3, 1'b0, "t3 rd dev ack");
        expect_evt("R", 8'd6, 8'h00);
        recv_byte(1'b0, 8'h45, "t3 byte0");
        expect_evt("R", 8'd7, 8'h00);
        recv_byte(1'b0, 8'h46, "t3 byte1");
        recv_byte(1'b1, 8'h47, "t3 byte2");
        send_stop();
        tick(Q);
        check("t3 busy after stop", 32'(busy), 0);
        check("t3 reg_addr", 32'(reg_addr), 7);
        // wrong device address
        send_start();
        send_byte(8'hA0, 1'b1, "t4 dev nack");
        send_byte(8'h01, 1'b1, "t4 ignored ptr");
        send_byte(8'h55, 1'b1, "t4 ignored data");
        send_stop();
        tick(Q);
        check("t4 busy", 32'(busy), 0);
        check("t4 reg_addr", 32'(reg_addr), 7);
        // out-of-range pointer
        send_start();
        send_byte(8'hD2, 1'b0, "t5 dev ack");
        send_byte(8'h20, 1'b1, "t5 ptr nack");
        send_byte(8'h77, 1'b1, "t5 data ignored");
        send_stop();
        tick(Q);
        check("t5 reg_addr", 32'(reg_addr), 7);
        // reset while driving a read bit low
        send_start();
        send_byte(8'hD2, 1'b0, "t6 dev ack");
        send_byte(8'h02, 1'b0, "t6 ptr ack");
        send_start();
        expect_evt("R", 8'd2, 8'h00);
        send_byte(8'hD3, 1'b0, "t6 rd dev ack");
        check("t6 sda_o bit7 low", 32'(sda_o), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6 rst sda_o", 32'(sda_o), 1);
        check("t6 rst busy", 32'(busy), 0);
        check("t6 rst reg_addr", 32'(reg_addr), 0);
        reset = 1'b0;
        tick(Q);
        send_start();
        send_byte(8'hD2, 1'b0, "t6 post dev ack");
        send_byte(8'h09, 1'b0, "t6 post ptr ack");
        expect_evt("W", 8'd9, 8'h5A);
        send_byte(8'h5A, 1'b0, "t6 post data ack");
        send_stop();
        tick(20);
        check("t6 post reg_addr", 32'(reg_addr), 10);
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
